// File: rtl/imp_axis_seq_divider.sv
// imp_axis_seq_divider
// Sequential unsigned radix-2 restoring divider with AXI-Stream-style
// dividend, divisor and result channels. One quotient bit is produced per
// clock, and each operand channel has a one-entry buffer so that the next
// pair can be accepted while the current division is still running.

module imp_axis_seq_divider #(
    parameter int DIVIDEND_W = 18,
    parameter int DIVISOR_W  = 4
) (
    input  logic                              i_clk,
    input  logic                              i_rst,
    input  logic                              i_dividend_tvalid,
    output logic                              o_dividend_tready,
    input  logic [DIVIDEND_W-1:0]             i_dividend_tdata,
    input  logic                              i_divisor_tvalid,
    output logic                              o_divisor_tready,
    input  logic [DIVISOR_W-1:0]              i_divisor_tdata,
    output logic                              o_dout_tvalid,
    input  logic                              i_dout_tready,
    output logic [DIVIDEND_W+DIVISOR_W-1:0]   o_dout_tdata,
    output logic                              o_dout_tuser
);

    localparam int CNT_W = $clog2(DIVIDEND_W + 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        OUT
    } state_t;

    state_t                            r_state;

    // Operand buffers: one entry per channel, each with its own full flag.
    logic [DIVIDEND_W-1:0]             r_dividendBuf;
    logic                              r_dividendFull;
    logic [DIVISOR_W-1:0]              r_divisorBuf;
    logic                              r_divisorFull;

    // Working registers for the division in flight. The partial remainder is
    // always strictly below the divisor, so DIVISOR_W bits hold it; the extra
    // bit needed for the trial subtraction exists only in the shifted value.
    logic [DIVISOR_W-1:0]              r_rem;
    logic [DIVIDEND_W-1:0]             r_quo;
    logic [DIVISOR_W-1:0]              r_divisor;
    logic [CNT_W-1:0]                  r_count;

    // Registered result channel.
    logic                              r_doutValid;
    logic [DIVIDEND_W+DIVISOR_W-1:0]   r_doutData;
    logic                              r_doutUser;

    logic                              w_dividendFire;
    logic                              w_divisorFire;
    logic                              w_pairReady;
    logic                              w_doutFire;
    logic                              w_load;
    logic                              w_lastIter;
    logic [DIVISOR_W:0]                w_shifted;
    logic [DIVISOR_W:0]                w_trial;
    logic                              w_trialNeg;
    logic [DIVISOR_W-1:0]              w_nextRem;
    logic [DIVIDEND_W-1:0]             w_nextQuo;

    // Ready depends only on registered full flags, never on any tvalid.
    assign o_dividend_tready = !r_dividendFull;
    assign o_divisor_tready  = !r_divisorFull;
    assign o_dout_tvalid     = r_doutValid;
    assign o_dout_tdata      = r_doutData;
    assign o_dout_tuser      = r_doutUser;

    assign w_dividendFire = i_dividend_tvalid && !r_dividendFull;
    assign w_divisorFire  = i_divisor_tvalid && !r_divisorFull;
    assign w_pairReady    = r_dividendFull && r_divisorFull;
    assign w_doutFire     = r_doutValid && i_dout_tready;

    // A new pair is taken either from IDLE or on the edge the current result
    // is accepted; both cases use the registered full flags, so an operand
    // arriving on the same edge is only picked up one edge later.
    assign w_load = w_pairReady &&
                    ((r_state == IDLE) || ((r_state == OUT) && w_doutFire));

    assign w_lastIter = (r_count == CNT_W'(DIVIDEND_W - 1));

    // One restoring step: bring down the next dividend bit and try to
    // subtract the divisor. The top bit of the trial is its sign because the
    // shifted value is always below twice the divisor.
    assign w_shifted  = {r_rem, r_quo[DIVIDEND_W-1]};
    assign w_trial    = w_shifted - {1'b0, r_divisor};
    assign w_trialNeg = w_trial[DIVISOR_W];
    assign w_nextRem  = w_trialNeg ? w_shifted[DIVISOR_W-1:0] : w_trial[DIVISOR_W-1:0];
    assign w_nextQuo  = {r_quo[DIVIDEND_W-2:0], !w_trialNeg};

    // Dividend buffer: filled by a handshake, emptied when the FSM loads it.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_dividendFull <= 1'b0;
            r_dividendBuf  <= '0;
        end else if (w_dividendFire) begin
            r_dividendFull <= 1'b1;
            r_dividendBuf  <= i_dividend_tdata;
        end else if (w_load) begin
            r_dividendFull <= 1'b0;
        end
    end

    // Divisor buffer: filled by a handshake, emptied when the FSM loads it.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_divisorFull <= 1'b0;
            r_divisorBuf  <= '0;
        end else if (w_divisorFire) begin
            r_divisorFull <= 1'b1;
            r_divisorBuf  <= i_divisor_tdata;
        end else if (w_load) begin
            r_divisorFull <= 1'b0;
        end
    end

    // Division FSM: load a pair, iterate one quotient bit per clock, then
    // hold the registered result until the consumer takes it.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_rem       <= '0;
            r_quo       <= '0;
            r_divisor   <= '0;
            r_count     <= '0;
            r_doutValid <= 1'b0;
            r_doutData  <= '0;
            r_doutUser  <= 1'b0;
        end else if (w_load) begin
            r_rem       <= '0;
            r_quo       <= r_dividendBuf;
            r_divisor   <= r_divisorBuf;
            r_count     <= '0;
            r_doutValid <= 1'b0;
            if (r_divisorBuf == '0) begin
                // Zero divisor skips the iterations; the fixed result is
                // captured now and presented after one settle cycle in OUT.
                r_state    <= OUT;
                r_doutData <= {r_dividendBuf[DIVISOR_W-1:0], {DIVIDEND_W{1'b1}}};
                r_doutUser <= 1'b1;
            end else begin
                r_state <= CALC;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    r_state <= IDLE;
                end
                CALC: begin
                    r_rem   <= w_nextRem;
                    r_quo   <= w_nextQuo;
                    r_count <= r_count + CNT_W'(1);
                    if (w_lastIter) begin
                        r_state     <= OUT;
                        r_doutValid <= 1'b1;
                        r_doutData  <= {w_nextRem, w_nextQuo};
                        r_doutUser  <= 1'b0;
                    end
                end
                OUT: begin
                    if (!r_doutValid) begin
                        r_doutValid <= 1'b1;
                    end else if (i_dout_tready) begin
                        r_doutValid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_doutValid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imp_axis_seq_divider.sv
// Testbench for imp_axis_seq_divider: directed and random divisions checked
// against an arithmetic reference (plain / and %), plus latency, stalling,
// staggered operands and mid-division reset.

module tb_imp_axis_seq_divider;

    localparam int DW = 18;
    localparam int VW = 4;
    localparam int OW = DW + VW;

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic          i_dividend_tvalid;
    logic          o_dividend_tready;
    logic [DW-1:0] i_dividend_tdata;
    logic          i_divisor_tvalid;
    logic          o_divisor_tready;
    logic [VW-1:0] i_divisor_tdata;
    logic          o_dout_tvalid;
    logic          i_dout_tready;
    logic [OW-1:0] o_dout_tdata;
    logic          o_dout_tuser;

    int checks   = 0;
    int failures = 0;

    // Free-running clock, 10 time units per cycle.
    always #5 i_clk = ~i_clk;

    imp_axis_seq_divider #(
        .DIVIDEND_W (DW),
        .DIVISOR_W  (VW)
    ) dut (
        .i_clk             (i_clk),
        .i_rst             (i_rst),
        .i_dividend_tvalid (i_dividend_tvalid),
        .o_dividend_tready (o_dividend_tready),
        .i_dividend_tdata  (i_dividend_tdata),
        .i_divisor_tvalid  (i_divisor_tvalid),
        .o_divisor_tready  (o_divisor_tready),
        .i_divisor_tdata   (i_divisor_tdata),
        .o_dout_tvalid     (o_dout_tvalid),
        .i_dout_tready     (i_dout_tready),
        .o_dout_tdata      (o_dout_tdata),
        .o_dout_tuser      (o_dout_tuser)
    );

    // Reference result: {remainder, quotient}, with the fixed pattern for a
    // zero divisor.
    function automatic logic [OW-1:0] refData(input logic [DW-1:0] a, input logic [VW-1:0] b);
        logic [DW-1:0] q;
        logic [VW-1:0] r;
        if (b == '0) begin
            q = '1;
            r = a[VW-1:0];
        end else begin
            q = DW'(a / b);
            r = VW'(a % b);
        end
        return {r, q};
    endfunction

    // Edges from the last operand handshake until tvalid is first seen high.
    function automatic int refLatency(input logic [VW-1:0] b);
        return (b == '0) ? 2 : DW + 1;
    endfunction

    task automatic tick;
        @(posedge i_clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Present a pair on both channels and hold each valid until accepted.
    task automatic applyStimulus(input logic [DW-1:0] a, input logic [VW-1:0] b);
        int   n;
        logic dA;
        logic dB;
        n = 0;
        i_dividend_tdata  = a;
        i_divisor_tdata   = b;
        i_dividend_tvalid = 1'b1;
        i_divisor_tvalid  = 1'b1;
        while ((i_dividend_tvalid || i_divisor_tvalid) && n < 100) begin
            dA = o_dividend_tready;
            dB = o_divisor_tready;
            tick;
            n++;
            if (dA) i_dividend_tvalid = 1'b0;
            if (dB) i_divisor_tvalid = 1'b0;
        end
        checkOutput("operand_accept", {i_dividend_tvalid, i_divisor_tvalid}, 2'b00);
        i_dividend_tvalid = 1'b0;
        i_divisor_tvalid  = 1'b0;
    endtask

    task automatic waitResult(input int maxCycles, output int n);
        n = 0;
        while (!o_dout_tvalid && n < maxCycles) begin
            tick;
            n++;
        end
        checkOutput("result_timeout", o_dout_tvalid, 1'b1);
    endtask

    // Full transaction with an always-ready consumer.
    task automatic runPair(input string tag, input logic [DW-1:0] a, input logic [VW-1:0] b);
        int n;
        applyStimulus(a, b);
        waitResult(60, n);
        checkOutput({tag, "_latency"}, n, refLatency(b));
        checkOutput({tag, "_data"}, o_dout_tdata, refData(a, b));
        checkOutput({tag, "_user"}, o_dout_tuser, (b == '0));
        tick;
        checkOutput({tag, "_valid_drop"}, o_dout_tvalid, 1'b0);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_dividend_tready"}, o_dividend_tready, 1'b1);
        checkOutput({tag, "_divisor_tready"}, o_divisor_tready, 1'b1);
        checkOutput({tag, "_tvalid"}, o_dout_tvalid, 1'b0);
        checkOutput({tag, "_tdata"}, o_dout_tdata, '0);
        checkOutput({tag, "_tuser"}, o_dout_tuser, 1'b0);
    endtask

    // Directed sequence followed by random pairs and the handshake scenarios.
    initial begin
        int            n;
        int            sawValid;
        logic [DW-1:0] ra;
        logic [VW-1:0] rb;
        logic [OW-1:0] held;

        i_rst             = 1'b1;
        i_dividend_tvalid = 1'b0;
        i_dividend_tdata  = '0;
        i_divisor_tvalid  = 1'b0;
        i_divisor_tdata   = '0;
        i_dout_tready     = 1'b1;
        tick;
        tick;
        checkResetState("reset");
        i_rst = 1'b0;
        tick;

        runPair("basic", 18'd1000, 4'd8);
        runPair("remainder", 18'd1003, 4'd7);
        runPair("fullscale", 18'd262143, 4'd1);
        runPair("divzero", 18'd500, 4'd0);

        for (int i = 0; i < 16; i++) begin
            ra = DW'($urandom);
            rb = ($urandom_range(0, 5) == 0) ? 4'd0 : VW'($urandom_range(1, 15));
            $display("[TB] random pair %0d: %0d / %0d", i, ra, rb);
            runPair("random", ra, rb);
        end

        // Staggered operands, second pair during CALC, stalled consumer.
        i_dout_tready    = 1'b0;
        i_divisor_tdata  = 4'd7;
        i_divisor_tvalid = 1'b1;
        tick;
        i_divisor_tvalid = 1'b0;
        checkOutput("stag_ready_partial", {o_dividend_tready, o_divisor_tready}, 2'b10);
        repeat (4) tick;
        i_dividend_tdata  = 18'd1003;
        i_dividend_tvalid = 1'b1;
        tick;
        i_dividend_tvalid = 1'b0;
        tick;
        checkOutput("stag_ready_after_load", {o_dividend_tready, o_divisor_tready}, 2'b11);
        applyStimulus(18'd64, 4'd8);
        checkOutput("stag_second_buffered", {o_dividend_tready, o_divisor_tready}, 2'b00);
        waitResult(60, n);
        checkOutput("stag_latency", n + 2, DW + 1);
        held = refData(18'd1003, 4'd7);
        for (int i = 0; i < 10; i++) begin
            checkOutput("stall_tvalid", o_dout_tvalid, 1'b1);
            checkOutput("stall_tdata", o_dout_tdata, held);
            tick;
        end
        i_dout_tready = 1'b1;
        tick;
        checkOutput("stag_next_loaded_valid", o_dout_tvalid, 1'b0);
        checkOutput("stag_ready_after_reload", {o_dividend_tready, o_divisor_tready}, 2'b11);
        waitResult(60, n);
        checkOutput("stag_second_latency", n + 1, DW + 1);
        checkOutput("stag_second_data", o_dout_tdata, refData(18'd64, 4'd8));
        checkOutput("stag_second_user", o_dout_tuser, 1'b0);
        tick;

        // Reset during CALC with another pair waiting in the buffers.
        applyStimulus(18'd100, 4'd3);
        tick;
        applyStimulus(18'd50, 4'd5);
        repeat (4) tick;
        i_rst = 1'b1;
        tick;
        i_rst = 1'b0;
        checkResetState("midcalc_reset");
        sawValid = 0;
        for (int i = 0; i < 40; i++) begin
            if (o_dout_tvalid) sawValid++;
            tick;
        end
        checkOutput("midcalc_no_result", sawValid, 0);
        runPair("after_reset", 18'd9, 4'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
